// File: rtl/cla96_pkg.sv
// Shared constants and types for the 96-bit pipelined carry-lookahead add/subtract datapath.
package cla96_pkg;
  localparam int CLA96_WIDTH = 96;
  localparam int CLA96_SEG_W = 24;
  localparam int CLA96_NSEG  = 4;
  localparam int GRP_W       = 4;

  typedef logic [CLA96_SEG_W-1:0] seg_t;
endpackage

// File: rtl/cla24_seg.sv
// Combinational segment adder: 4-bit lookahead groups, carry rippled group to group.
module cla24_seg
  import cla96_pkg::*;
#(
  parameter int SEG_W = CLA96_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  localparam int NGRP = SEG_W / GRP_W;

  logic [NGRP:0] gc;
  assign gc[0] = cin;

  genvar gi;
  for (gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [GRP_W-1:0] p, g, c;
    assign p = a[gi*GRP_W +: GRP_W] ^ b[gi*GRP_W +: GRP_W];
    assign g = a[gi*GRP_W +: GRP_W] & b[gi*GRP_W +: GRP_W];
    assign c[0] = gc[gi];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (g[0] & p[1]) | (c[0] & p[0] & p[1]);
    assign c[3] = g[2] | (g[1] & p[2]) | (g[0] & p[1] & p[2]) | (c[0] & p[0] & p[1] & p[2]);
    assign gc[gi+1] = g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3])
                    | (c[0] & p[0] & p[1] & p[2] & p[3]);
    assign s[gi*GRP_W +: GRP_W] = p ^ c;
  end

  assign cout  = gc[NGRP];
  assign c_msb = g_grp[NGRP-1].c[GRP_W-1];
endmodule

// File: rtl/cla96_pipe_addsub.sv
// Pipelined add/subtract: one SEG_W segment resolved per stage, operands skewed forward,
// finished low segments de-skewed alongside, whole pipe advancing on a single enable.
module cla96_pipe_addsub
  import cla96_pkg::*;
#(
  parameter int WIDTH = CLA96_WIDTH,
  parameter int SEG_W = CLA96_SEG_W,
  parameter int NSEG  = CLA96_NSEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  logic             adv;
  logic [NSEG-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0] b_eff;

  assign adv      = ~valid_q[NSEG-1] | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign valid_d  = {valid_q[NSEG-2:0], in_valid};

  always_ff @(posedge clk) begin
    if (rst)      valid_q <= '0;
    else if (adv) valid_q <= valid_d;
  end

  genvar gi;
  for (gi = 0; gi < NSEG; gi++) begin : g_stage
    localparam int REM  = (NSEG - 1 - gi) * SEG_W;
    localparam int DONE = (gi + 1) * SEG_W;

    logic [REM+SEG_W-1:0] src_a, src_b;
    logic                 src_c;
    logic [SEG_W-1:0]     seg_s;
    logic                 seg_cout, seg_cmsb;
    logic [DONE-1:0]      res_d, res_q;
    logic                 carry_q;

    if (gi == 0) begin : g_src
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = sub ? 1'b1 : c_in;
      assign res_d = seg_s;
    end else begin : g_src
      assign src_a = g_stage[gi-1].g_ops.opa_q;
      assign src_b = g_stage[gi-1].g_ops.opb_q;
      assign src_c = g_stage[gi-1].carry_q;
      assign res_d = {seg_s, g_stage[gi-1].res_q};
    end

    cla24_seg #(.SEG_W(SEG_W)) u_seg (
      .a     (src_a[SEG_W-1:0]),
      .b     (src_b[SEG_W-1:0]),
      .cin   (src_c),
      .s     (seg_s),
      .cout  (seg_cout),
      .c_msb (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        res_q   <= '0;
        carry_q <= 1'b0;
      end else if (adv) begin
        res_q   <= res_d;
        carry_q <= seg_cout;
      end
    end

    if (gi < NSEG - 1) begin : g_ops
      // Pending upper operand segments; qualified by valid, so no reset needed.
      logic [REM-1:0] opa_q, opb_q;
      logic           cmsb_unused;
      assign cmsb_unused = seg_cmsb;

      always_ff @(posedge clk) begin
        if (adv) begin
          opa_q <= src_a[REM+SEG_W-1:SEG_W];
          opb_q <= src_b[REM+SEG_W-1:SEG_W];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= seg_cmsb ^ seg_cout;
      end
    end
  end

  assign out_valid = valid_q[NSEG-1];
  assign sum       = g_stage[NSEG-1].res_q;
  assign c_out     = g_stage[NSEG-1].carry_q;
  assign ovf       = g_stage[NSEG-1].g_last.ovf_q;
endmodule

// File: tb/tb_cla96_pipe_addsub.sv
// Bench for cla96_pipe_addsub: directed vectors, reset flush, back-pressure and random
// traffic, all results checked in order against a scoreboard queue.
module tb_cla96_pipe_addsub;
  localparam int W = 96;
  typedef logic [W+1:0] res_t;  // {ovf, c_out, sum}

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, ovf;
  logic [W-1:0] a, b, sum;

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cla96_pipe_addsub dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv, input logic cv);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         o;
    be = sv ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, (sv ? 1'b1 : cv)};
    o  = (av[W-1] == be[W-1]) && (r[W-1] != av[W-1]);
    return {o, r};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // Output side: every beat taken downstream must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("beat_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        res_t e;
        e = exp_q.pop_front();
        check("result", 128'({ovf, c_out, sum}), 128'(e));
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sv, input logic cv, input res_t ev);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    a = av; b = bv; sub = sv; c_in = cv; in_valid = 1'b1;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ev);
        done = 1'b1;
      end
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    check("send_accepted", 128'(done), 128'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int lat;
    int seen;
    int beat;
    logic [W-1:0] bp_a [10];
    logic [W-1:0] bp_b [10];
    logic         bp_s [10];
    logic         bp_c [10];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_sum", 128'(sum), 128'd0);
    check("reset_c_out", 128'(c_out), 128'd0);
    check("reset_ovf", 128'(ovf), 128'd0);
    check("reset_in_ready", 128'(in_ready), 128'd1);

    // Full carry ripple across every segment, also used to measure latency.
    send({W{1'b1}}, 96'd1, 1'b0, 1'b0, {1'b0, 1'b1, 96'h0});
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 128'(lat), 128'd4);
    drain();

    send(96'd5, 96'd7, 1'b1, 1'b0, {1'b0, 1'b0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
    send(96'd7, 96'd5, 1'b1, 1'b0, {1'b0, 1'b1, 96'd2});
    send(96'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'd1, 1'b0, 1'b0,
         {1'b1, 1'b0, 96'h8000_0000_0000_0000_0000_0000});
    send(96'd123, 96'd0, 1'b1, 1'b0, {1'b0, 1'b1, 96'd123});
    send(96'd1, 96'd2, 1'b0, 1'b1, {1'b0, 1'b0, 96'd4});
    send(96'd10, 96'd3, 1'b1, 1'b1, {1'b0, 1'b1, 96'd7});
    drain();

    // Reset with two beats in flight: neither may ever emerge.
    send(96'd11, 96'd22, 1'b0, 1'b0, {1'b0, 1'b0, 96'd33});
    send(96'd44, 96'd55, 1'b0, 1'b0, {1'b0, 1'b0, 96'd99});
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_ghost_beats", 128'(seen), 128'd0);
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);

    // Back-pressure: 10 beats, downstream stalls during cycles 6-9.
    for (int i = 0; i < 10; i++) begin
      bp_a[i] = {$urandom(), $urandom(), $urandom()};
      bp_b[i] = {$urandom(), $urandom(), $urandom()};
      bp_s[i] = 1'($urandom_range(0, 1));
      bp_c[i] = 1'($urandom_range(0, 1));
    end
    beat = 0;
    for (int i = 0; i < 14; i++) begin
      out_ready = !(i >= 6 && i <= 9);
      in_valid  = (beat < 10);
      if (beat < 10) begin
        a = bp_a[beat]; b = bp_b[beat]; sub = bp_s[beat]; c_in = bp_c[beat];
      end
      @(negedge clk);
      check("bp_in_ready", 128'(in_ready), 128'(!(i >= 6 && i <= 9)));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub, c_in));
        beat++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 128'(beat), 128'd10);
    drain();

    // Random traffic with random handshakes on both sides.
    for (int i = 0; i < 10000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a    = {$urandom(), $urandom(), $urandom()};
      b    = {$urandom(), $urandom(), $urandom()};
      sub  = 1'($urandom_range(0, 1));
      c_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) b = ~a;
      if ($urandom_range(0, 15) == 0) a = {W{1'b1}};
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, c_in));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
